// File: rtl/eyeriss_pkg.sv
// Shared constants for the Eyeriss-style row sequencer: FSM encoding and Q4.12 data format.
// Pure declarations; no logic, no latency, no flow control.
package eyeriss_pkg;

  localparam int INWIDTH_DEF = 16;
  localparam int FRAC        = 12;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_W = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/seq_win3.sv
// 3-tap sliding pixel window: holds the two previous pixels and the in-row pixel index.
// Updates one cycle after each shift; no flow control of its own, the parent gates shift.
module seq_win3
  import eyeriss_pkg::*;
#(
  parameter int INWIDTH = INWIDTH_DEF,
  parameter int ROW_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic [INWIDTH-1:0] din,
  output logic [INWIDTH-1:0] x1,
  output logic [INWIDTH-1:0] x2,
  output logic [7:0]         pix_cnt,
  output logic               last
);

  localparam logic [7:0] LAST_IDX = 8'(ROW_LEN - 1);

  assign last = (pix_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x1      <= '0;
      x2      <= '0;
      pix_cnt <= '0;
    end else if (shift) begin
      x1      <= x2;
      x2      <= din;
      pix_cnt <= last ? 8'd0 : pix_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/conv_row_seq.sv
// Row sequencer for a 3-tap 1-D convolution feeding an external vector multiplier (PSUM_ACC_EN adds psum input).
// Output registered one cycle after each pixel from the third on; pixels stall while the output is held.
// Backpressure: o_ready low holds o_valid/o_data and drops if_ready; w_ready only while loading weights.
module conv_row_seq
  import eyeriss_pkg::*;
#(
  parameter int INWIDTH = INWIDTH_DEF,
  parameter int ROW_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [INWIDTH-1:0] w_data,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INWIDTH-1:0] if_data,
  output logic [INWIDTH-1:0] dp_a0,
  output logic [INWIDTH-1:0] dp_a1,
  output logic [INWIDTH-1:0] dp_a2,
  output logic [INWIDTH-1:0] dp_b0,
  output logic [INWIDTH-1:0] dp_b1,
  output logic [INWIDTH-1:0] dp_b2,
  input  logic [INWIDTH-1:0] dp_res,
`ifdef PSUM_ACC_EN
  input  logic               ps_valid,
  output logic               ps_ready,
  input  logic [INWIDTH-1:0] ps_data,
`endif
  output logic               o_valid,
  input  logic               o_ready,
  output logic [INWIDTH-1:0] o_data
);

  logic [1:0]         state;
  logic [1:0]         w_cnt;
  logic [INWIDTH-1:0] w0, w1, w2;
  logic [INWIDTH-1:0] x1, x2;
  logic [7:0]         pix_cnt;
  logic               last;
  logic               win_clr, w_hs, pix_hs, o_load, pix_ge2, out_free, in_run;
  logic [INWIDTH-1:0] psum_val;

  assign busy     = (state != ST_IDLE);
  assign in_run   = (state == ST_RUN);
  assign w_ready  = (state == ST_LOAD_W);
  assign w_hs     = w_valid && w_ready;
  assign win_clr  = (state == ST_IDLE) && start;
  assign pix_ge2  = (pix_cnt > 8'd1);
  assign out_free = !o_valid || o_ready;

  // The first two pixels only prime the window, so they never wait on the output.
`ifdef PSUM_ACC_EN
  assign if_ready = in_run && (!pix_ge2 || (out_free && ps_valid));
  assign ps_ready = if_valid && if_ready && pix_ge2;
  assign psum_val = dp_res + ps_data;
`else
  assign if_ready = in_run && (!pix_ge2 || out_free);
  assign psum_val = dp_res;
`endif

  assign pix_hs = if_valid && if_ready;
  assign o_load = pix_hs && pix_ge2;

  assign dp_a0 = x1;
  assign dp_a1 = x2;
  assign dp_a2 = if_data;
  assign dp_b0 = w0;
  assign dp_b1 = w1;
  assign dp_b2 = w2;

  seq_win3 #(
    .INWIDTH (INWIDTH),
    .ROW_LEN (ROW_LEN)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .clr     (win_clr),
    .shift   (pix_hs),
    .din     (if_data),
    .x1      (x1),
    .x2      (x2),
    .pix_cnt (pix_cnt),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      w_cnt <= '0;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD_W;
            w_cnt <= '0;
          end
        end
        ST_LOAD_W: begin
          if (w_hs) begin
            case (w_cnt)
              2'd0:    w0 <= w_data;
              2'd1:    w1 <= w_data;
              default: w2 <= w_data;
            endcase
            w_cnt <= w_cnt + 2'd1;
            if (w_cnt == 2'd2) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pix_hs && last) state <= ST_DRAIN;
        end
        default: begin
          // Leave as the final output handshakes, so o_valid and busy fall together with done.
          if (out_free) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (o_load) begin
      o_valid <= 1'b1;
      o_data  <= psum_val;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_row_seq.sv
// Bench for conv_row_seq: directed rows with a queue scoreboard popped by an output monitor.
module tb_conv_row_seq;
  import eyeriss_pkg::*;

  localparam int W  = INWIDTH_DEF;
  localparam int RL = 16;
  localparam logic [W-1:0] ONE = W'(1 << FRAC);

  logic         clk = 1'b0;
  logic         rst, start, busy, done;
  logic         w_valid, w_ready, if_valid, if_ready, o_valid, o_ready;
  logic [W-1:0] w_data, if_data, o_data, dp_res;
  logic [W-1:0] dp_a0, dp_a1, dp_a2, dp_b0, dp_b1, dp_b2;
`ifdef PSUM_ACC_EN
  logic         ps_valid, ps_ready;
  logic [W-1:0] ps_data;
`endif

  logic [W-1:0] px [RL];
  logic [W-1:0] exp_q [$];
  int           cyc_q [$];
  logic [W-1:0] ps_add;
  int n_vec, n_err, cyc, done_cnt, out_cnt, ph;
  bit tog_en, stall_en, lat_en;

  always #5 clk = ~clk;

  conv_row_seq #(.INWIDTH(W), .ROW_LEN(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
    .dp_a0(dp_a0), .dp_a1(dp_a1), .dp_a2(dp_a2),
    .dp_b0(dp_b0), .dp_b1(dp_b1), .dp_b2(dp_b2), .dp_res(dp_res),
`ifdef PSUM_ACC_EN
    .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data),
`endif
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  // External Q4.12 3-tap multiplier
  function automatic logic [W-1:0] q_dot(input logic [W-1:0] a0, a1, a2, b0, b1, b2);
    logic signed [31:0] s;
    s = $signed({{16{a0[15]}}, a0}) * $signed({{16{b0[15]}}, b0})
      + $signed({{16{a1[15]}}, a1}) * $signed({{16{b1[15]}}, b1})
      + $signed({{16{a2[15]}}, a2}) * $signed({{16{b2[15]}}, b2});
    return s[27:12];
  endfunction
  assign dp_res = q_dot(dp_a0, dp_a1, dp_a2, dp_b0, dp_b1, dp_b2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_w(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] wv [3];
    wv[0] = a; wv[1] = b; wv[2] = c;
    w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int t;
      w_data = wv[i];
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 50) begin @(negedge clk); t++; end
      chk("w_ready_timeout", w_ready, 1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  // sel 0: out = x1, sel 1: out = x2, other: all-ones weights on 0x1000 pixels
  task automatic send_row(input int sel, input int npix, input int mid_start, input int hold_at);
    for (int k = 0; k < npix; k++) begin
      int t;
      logic [W-1:0] e;
      if_valid = 1'b1;
      if_data  = px[k];
      if (k == mid_start) start = 1'b1;
`ifdef PSUM_ACC_EN
      if (k == hold_at) begin
        ps_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("ps_hold_if_ready", if_ready, 0);
        end
        ps_valid = 1'b1;
      end
`endif
      t = 0;
      @(negedge clk);
      while (!if_ready && t < 200) begin @(negedge clk); t++; end
      chk("if_ready_timeout", if_ready, 1);
      if (k == mid_start) chk("start_in_run_busy", busy, 1);
      if (k >= 2) begin
        case (sel)
          0:       e = px[k-2];
          1:       e = px[k-1];
          default: e = 16'h3000;
        endcase
        exp_q.push_back(e + ps_add);
        cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if_valid = 1'b0;
  endtask

  task automatic finish_row(input string tag, input int d0, input int o0, input int nout);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_out_count"}, out_cnt - o0, nout);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_busy_idle"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_ready"}, w_ready, 0);
    chk({tag, "_if_ready"}, if_ready, 0);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_o_data"}, o_data, 0);
    chk({tag, "_w0"}, dp_b0, 0);
    chk({tag, "_x1"}, dp_a0, 0);
  endtask

  initial begin
    int d0, o0;
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0;
    if_valid = 1'b0; if_data = '0; o_ready = 1'b1; ps_add = '0;
`ifdef PSUM_ACC_EN
    ps_valid = 1'b1; ps_data = '0;
`endif
    n_vec = 0; n_err = 0; cyc = 0; done_cnt = 0; out_cnt = 0; ph = 0;
    tog_en = 1'b0; stall_en = 1'b0; lat_en = 1'b0;
    fork
      forever begin
        @(posedge clk);
        cyc = cyc + 1;
      end
      forever begin
        @(posedge clk); #1;
        if (tog_en) begin
          o_ready = (ph == 0);
          ph = (ph == 2) ? 0 : ph + 1;
        end else begin
          o_ready = 1'b1;
        end
      end
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (done) done_cnt++;
          if (o_valid && o_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
              chk("unexpected_output", 1, 0);
            end else begin
              logic [W-1:0] e;
              int c;
              e = exp_q.pop_front();
              c = cyc_q.pop_front();
              chk("o_data", o_data, e);
              if (lat_en) chk("latency", cyc, c + 1);
            end
          end
          if (stall_en && o_valid && !o_ready) chk("stall_if_ready", if_ready, 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Row 1: identity on x1, pixels 1..16
        lat_en = 1'b1;
        d0 = done_cnt; o0 = out_cnt;
        for (int k = 0; k < RL; k++) px[k] = W'(k + 1);
        do_start();
        load_w(ONE, 16'h0000, 16'h0000);
        send_row(0, RL, -1, -1);
        finish_row("row1", d0, o0, RL - 2);

        // Row 2: all-ones weights, output stalls 2 of every 3 cycles
        lat_en = 1'b0; tog_en = 1'b1; stall_en = 1'b1;
        d0 = done_cnt; o0 = out_cnt;
        for (int k = 0; k < RL; k++) px[k] = 16'h1000;
        do_start();
        load_w(ONE, ONE, ONE);
        send_row(2, RL, -1, -1);
        finish_row("row2", d0, o0, RL - 2);
        tog_en = 1'b0; stall_en = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Row 3: start pulsed mid-row, then a second row with retained weights
        lat_en = 1'b1;
        d0 = done_cnt; o0 = out_cnt;
        for (int k = 0; k < RL; k++) px[k] = W'(k + 1);
        do_start();
        load_w(ONE, 16'h0000, 16'h0000);
        send_row(0, RL, 5, -1);
        finish_row("row3", d0, o0, RL - 2);
        chk("w0_retained_idle", dp_b0, ONE);
        d0 = done_cnt; o0 = out_cnt;
        do_start();
        @(negedge clk);
        chk("w0_retained_load", dp_b0, ONE);
        chk("x1_cleared_load", dp_a0, 0);
        @(posedge clk); #1;
        for (int k = 0; k < RL; k++) px[k] = W'(3 * k);
        load_w(ONE, 16'h0000, 16'h0000);
        send_row(0, RL, -1, -1);
        finish_row("row4", d0, o0, RL - 2);

        // Reset after 7 pixels, then a fresh row on x2
        d0 = done_cnt;
        for (int k = 0; k < RL; k++) px[k] = W'(k + 1);
        do_start();
        load_w(ONE, 16'h0000, 16'h0000);
        send_row(0, 7, -1, -1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        d0 = done_cnt; o0 = out_cnt;
        for (int k = 0; k < RL; k++) px[k] = W'(32 * k + 5);
        do_start();
        load_w(16'h0000, ONE, 16'h0000);
        send_row(1, RL, -1, -1);
        finish_row("row5", d0, o0, RL - 2);

`ifdef PSUM_ACC_EN
        // Accumulate: 0x7000 + 0x2000 wraps to 0x9000; psum withheld stalls pixels
        ps_add = 16'h2000; ps_data = 16'h2000;
        d0 = done_cnt; o0 = out_cnt;
        px[0] = 16'h7000;
        for (int k = 1; k < RL; k++) px[k] = W'(256 * k);
        do_start();
        load_w(ONE, 16'h0000, 16'h0000);
        send_row(0, RL, -1, 4);
        finish_row("psum", d0, o0, RL - 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    join
  end

endmodule
